// File: rtl/i2c_pkg.sv
// Shared I2C constants and state encodings, used by both slave and master blocks.
package i2c_pkg;

    localparam int unsigned I2C_ADDR_W    = 7;
    localparam int unsigned I2C_BYTE_W    = 8;
    localparam int unsigned I2C_BIT_CNT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WRITE     = 3'd3,
        ST_WRITE_ACK = 3'd4,
        ST_READ      = 3'd5,
        ST_READ_ACK  = 3'd6,
        ST_IGNORE    = 3'd7
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchroniser plus delay flop for one bus line; registered edge pulses
// are aligned with level_o (new value), giving 3 clk of latency from the pad.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       dly_q;
    logic       rise_q;
    logic       fall_q;

    // Reset to 1 (idle bus) so releasing reset never fakes an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
            dly_q  <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            dly_q  <= sync_q[1];
            rise_q <= sync_q[1] & ~dly_q;
            fall_q <= ~sync_q[1] & dly_q;
        end
    end

    assign level_o = dly_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with single-byte write/read handshakes to the user side.
// Samples SDA on synchronised SCL rises, drives SDA only on synchronised SCL falls.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] I2C_ADDR = 7'h2A
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SCL_i,
    input  logic                  SDA_i,
    output logic                  SDA_o,
    output logic                  SDA_t,
    output logic [I2C_BYTE_W-1:0] data_o,
    output logic                  data_available,
    input  logic                  rx_ready,
    input  logic [I2C_BYTE_W-1:0] data_i,
    output logic                  data_request,
    output logic                  addressed
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync u_scl_sync (
        .clk    (clk),
        .rst    (rst),
        .line_i (SCL_i),
        .level_o(scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk    (clk),
        .rst    (rst),
        .line_i (SDA_i),
        .level_o(sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    i2c_state_e               state_q, state_d;
    logic [I2C_BYTE_W-1:0]    shift_q, shift_d;
    logic [I2C_BIT_CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [I2C_BYTE_W-1:0]    data_o_q, data_o_d;
    logic                     sda_o_q, sda_o_d;
    logic                     sda_t_q, sda_t_d;
    logic                     da_q, da_d;
    logic                     dr_q, dr_d;
    logic                     addr_q, addr_d;
    logic                     load_q, load_d;

    logic                  start, stop, last_bit, rw, addr_match;
    logic [I2C_BYTE_W-1:0] byte_in;

    assign start      = sda_fall & scl_lvl;
    assign stop       = sda_rise & scl_lvl;
    assign last_bit   = (bitcnt_q == 3'd7);
    assign byte_in    = {shift_q[I2C_BYTE_W-2:0], sda_lvl};
    assign addr_match = (byte_in[I2C_BYTE_W-1:1] == I2C_ADDR);
    assign rw         = shift_q[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // In ACK states sda_t_q tells the first (start driving) fall from the second.
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d = ST_ADDR;
        end else begin
            case (state_q)
                ST_ADDR:      if (scl_rise && last_bit) state_d = addr_match ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK:  if (scl_fall && !sda_t_q) state_d = rw ? ST_READ : ST_WRITE;
                ST_WRITE:     if (scl_rise && last_bit) state_d = rx_ready ? ST_WRITE_ACK : ST_IGNORE;
                ST_WRITE_ACK: if (scl_fall && !sda_t_q) state_d = ST_WRITE;
                ST_READ:      if (scl_rise && last_bit) state_d = ST_READ_ACK;
                ST_READ_ACK:  if (scl_rise)             state_d = sda_lvl ? ST_IGNORE : ST_READ;
                default:      state_d = state_q;
            endcase
        end
    end

    always_comb begin
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        data_o_d = data_o_q;
        sda_o_d  = sda_o_q;
        sda_t_d  = sda_t_q;
        da_d     = 1'b0;
        dr_d     = 1'b0;
        addr_d   = addr_q;
        load_d   = load_q;
        if (start || stop) begin
            sda_o_d  = 1'b1;
            sda_t_d  = 1'b1;
            addr_d   = 1'b0;
            bitcnt_d = '0;
            load_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d  = byte_in;
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
                ST_ADDR_ACK: begin
                    bitcnt_d = '0;
                    if (scl_rise && rw && !sda_t_q) begin
                        dr_d   = 1'b1;
                        load_d = 1'b1;
                    end
                    if (scl_fall) begin
                        if (sda_t_q) begin
                            sda_t_d = 1'b0;
                            sda_o_d = 1'b0;
                            addr_d  = 1'b1;
                        end else if (rw) begin
                            sda_t_d = 1'b0;
                            sda_o_d = data_i[7];
                            shift_d = {data_i[6:0], 1'b0};
                            load_d  = 1'b0;
                        end else begin
                            sda_t_d = 1'b1;
                            sda_o_d = 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (scl_fall) begin
                        sda_t_d = 1'b1;
                        sda_o_d = 1'b1;
                    end
                    if (scl_rise) begin
                        shift_d  = byte_in;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (last_bit) begin
                            data_o_d = byte_in;
                            da_d     = 1'b1;
                            if (!rx_ready) addr_d = 1'b0;
                        end
                    end
                end
                ST_WRITE_ACK: begin
                    bitcnt_d = '0;
                    if (scl_fall) begin
                        sda_t_d = ~sda_t_q;
                        sda_o_d = ~sda_t_q;
                    end
                end
                ST_READ: begin
                    if (scl_rise) bitcnt_d = bitcnt_q + 3'd1;
                    // A pending load means this fall starts a fresh byte.
                    if (scl_fall) begin
                        sda_t_d = 1'b0;
                        if (load_q) begin
                            sda_o_d = data_i[7];
                            shift_d = {data_i[6:0], 1'b0};
                            load_d  = 1'b0;
                        end else begin
                            sda_o_d = shift_q[7];
                            shift_d = {shift_q[6:0], 1'b0};
                        end
                    end
                end
                ST_READ_ACK: begin
                    bitcnt_d = '0;
                    if (scl_fall) begin
                        sda_t_d = 1'b1;
                        sda_o_d = 1'b1;
                    end
                    if (scl_rise) begin
                        if (!sda_lvl) begin
                            dr_d   = 1'b1;
                            load_d = 1'b1;
                        end else begin
                            addr_d = 1'b0;
                        end
                    end
                end
                default: begin
                    sda_t_d = 1'b1;
                    sda_o_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q  <= '0;
            bitcnt_q <= '0;
            data_o_q <= '0;
            sda_o_q  <= 1'b1;
            sda_t_q  <= 1'b1;
            da_q     <= 1'b0;
            dr_q     <= 1'b0;
            addr_q   <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            data_o_q <= data_o_d;
            sda_o_q  <= sda_o_d;
            sda_t_q  <= sda_t_d;
            da_q     <= da_d;
            dr_q     <= dr_d;
            addr_q   <= addr_d;
            load_q   <= load_d;
        end
    end

    assign SDA_o          = sda_o_q;
    assign SDA_t          = sda_t_q;
    assign data_o         = data_o_q;
    assign data_available = da_q;
    assign data_request   = dr_q;
    assign addressed      = addr_q;

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter I2C_ADDR, default 7'h2A, 7-bit target address answered by the block.
REQ-002 SHALL have ports clk input 1 (single clock) and rst input 1 (asynchronous, active-low reset).
REQ-003 SHALL have SCL_i input 1, bus clock line as observed on the pad (the block never drives SCL).
REQ-004 SHALL have SDA_i input 1, SDA_o output 1, SDA_t output 1: bus data in, value driven, tri-state enable (1 = released).
REQ-005 SHALL have data_o output 8, last byte written by the master.
REQ-006 SHALL have data_available output 1, one-clk pulse when data_o is updated.
REQ-007 SHALL have rx_ready input 1, user can accept a written byte (0 = NACK it).
REQ-008 SHALL have data_i input 8, next byte to return to the master on a read.
REQ-009 SHALL have data_request output 1, one-clk pulse requesting data_i for the next read byte.
REQ-010 SHALL have addressed output 1, high from address ACK until STOP, repeated START or NACK exit.

Function
REQ-011 SHALL pass SCL_i and SDA_i through 2-flop synchronisers plus a delay flop; edges are detected on synchronised values (3-clk latency).
REQ-012 SHALL require clk >= 16x SCL frequency; behaviour below that is undefined.
REQ-013 SHALL detect START as a synchronised SDA fall while SCL is high, and STOP as an SDA rise while SCL is high.
REQ-014 SHALL implement states IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
REQ-015 SHALL sample SDA on every synchronised SCL rise and change SDA_o/SDA_t only on synchronised SCL falls.
REQ-016 SHALL go from IDLE to ADDR on START, and from ADDR on the 8th SCL rise shift in 8 address/RW bits, MSB first.
REQ-017 On address match, SHALL drive ACK (SDA_t=0, SDA_o=0) from the next SCL fall to the following SCL fall (ADDR_ACK), set addressed, then enter WRITE (RW=0) or READ (RW=1).
REQ-018 On address mismatch, SHALL leave SDA released and enter IGNORE until the next START or STOP.
REQ-019 In WRITE, after the 8th SCL rise, SHALL load data_o, pulse data_available, and ACK in WRITE_ACK if rx_ready=1, else NACK (release) and go to IGNORE.
REQ-020 SHALL pulse data_request on the SCL rise of the address ACK (read) and of each master ACK (SDA=0) in READ_ACK.
REQ-021 SHALL latch data_i into the shift register at the SCL fall following data_request and drive bit 7 immediately; the user has half an SCL period to present data_i.
REQ-022 SHALL release SDA in READ_ACK; master ACK returns to READ, master NACK (SDA=1) goes to IGNORE.
REQ-023 SHALL use a 3-bit bit counter that wraps 7->0 at each byte boundary and is cleared on START and in every ACK state.
REQ-024 On a repeated START in any state, SHALL release SDA, clear addressed, and enter ADDR.
REQ-025 On STOP in any state, SHALL release SDA, clear addressed, and enter IDLE; it SHALL NOT pulse data_available for a partial byte.
REQ-026 SHALL treat START and STOP as taking priority over data-bit edges detected in the same clk.
REQ-027 SHALL not respond to the general call address (7'h00) unless I2C_ADDR is 0.

Reset
REQ-028 While rst=0, SHALL hold state=IDLE, SDA_t=1, SDA_o=1, data_o=8'h00, data_available=0, data_request=0, addressed=0, counters=0, synchronisers=1.
REQ-029 Reset assertion mid-transfer SHALL release SDA asynchronously; after release the block SHALL wait in IDLE for a fresh START.

Structure
REQ-030 SHALL take state encodings and the I2C address width constant from a shared package i2c_pkg, which is also available to the master.
REQ-031 SHALL use one sub-module, i2c_line_sync (synchroniser + edge detect), instantiated once for SCL and once for SDA.

Verification
REQ-032 Write 0x2A,W then 0x5C with rx_ready=1 -> address ACK, data_o=0x5C, one data_available pulse, byte ACKed, addressed=0 after STOP.
REQ-033 Read 0x2A,R with data_i=0xA5 then 0x3C, master ACK then NACK -> two data_request pulses, bus carries A5 then 3C, SDA released after NACK.
REQ-034 Address 0x2B,W -> SDA_t=1 throughout, no data_available pulse, IGNORE until STOP.
REQ-035 Write with rx_ready=0 on the 2nd byte -> 1st byte ACKed, 2nd byte NACKed, block enters IGNORE.
REQ-036 Repeated START after 4 bits of a write byte, then 0x2A,R -> no data_available pulse, address ACK, READ entered.
REQ-037 rst=0 asserted while driving ACK -> SDA_t=1 within the same clk, state IDLE, next START is handled normally.
